// File: rtl/pwm_pkg.sv
// Shared constants, types and the level comparator for the multi-channel PWM block.
// The register map below is decoded by pwm_multi_channel; the timebase uses the enums.
package pwm_pkg;

    localparam logic [6:0] ADDR_OUT_EN    = 7'h00;
    localparam logic [6:0] ADDR_PWM_EN    = 7'h04;
    localparam logic [6:0] ADDR_CTRL      = 7'h08;
    localparam logic [6:0] ADDR_PRESC     = 7'h09;
    localparam logic [6:0] ADDR_DUTY_BASE = 7'h10;

    localparam int CTRL_CENTER = 0;
    localparam int CTRL_RUN    = 1;

    localparam logic [7:0] DUTY_MAX = 8'hFF;
    localparam logic [7:0] EDGE_TOP = 8'd254;
    localparam logic [7:0] CNT_TOP  = 8'hFF;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } mode_e;

    // Full-scale duty forces the output high even when cnt reaches 255 in center mode.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == DUTY_MAX) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, shared period counter and direction state for all PWM channels.
// wrap_o says the next tick returns cnt to 0; tick_o & wrap_o is the period boundary.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run_i,
    input  logic               center_i,
    input  logic [PRESC_W-1:0] presc_i,
    output logic [7:0]         cnt_o,
    output logic               tick_o,
    output logic               wrap_o,
    output logic               period_start_o
);

    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [7:0]         cnt_q, cnt_d, cnt_step;
    dir_e               dir_q, dir_d, dir_step;
    mode_e              mode_q, mode_d, mode_sel;
    logic               tick, wrap, boundary;
    logic               boundary_q, period_start_q;

    assign mode_sel = center_i ? MODE_CENTER : MODE_EDGE;

    // Count value and direction the next tick would produce in the active mode.
    always_comb begin
        cnt_step = cnt_q + 8'd1;
        dir_step = dir_q;
        if (mode_q == MODE_EDGE) begin
            cnt_step = (cnt_q == EDGE_TOP) ? 8'd0 : cnt_q + 8'd1;
            dir_step = DIR_UP;
        end else if (dir_q == DIR_UP) begin
            if (cnt_q == CNT_TOP) begin
                cnt_step = CNT_TOP - 8'd1;
                dir_step = DIR_DOWN;
            end
        end else begin
            cnt_step = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                dir_step = DIR_UP;
            end
        end
    end

    assign tick     = run_i && (pcnt_q == presc_i);
    assign wrap     = (cnt_step == 8'd0);
    assign boundary = tick && wrap;

    always_comb begin
        pcnt_d = pcnt_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        if (!run_i) begin
            pcnt_d = '0;
            cnt_d  = 8'd0;
            dir_d  = DIR_UP;
            mode_d = mode_sel;
        end else begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
            if (tick) begin
                cnt_d = cnt_step;
                dir_d = dir_step;
            end
            // A mode change only lands on a boundary so a period is never cut short.
            if (boundary) begin
                mode_d = mode_sel;
                if (mode_sel != mode_q) begin
                    dir_d = DIR_UP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q         <= '0;
            cnt_q          <= 8'd0;
            dir_q          <= DIR_UP;
            mode_q         <= MODE_EDGE;
            boundary_q     <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pcnt_q         <= pcnt_d;
            cnt_q          <= cnt_d;
            dir_q          <= dir_d;
            mode_q         <= mode_d;
            boundary_q     <= boundary;
            period_start_q <= boundary_q;
        end
    end

    // Two-stage delay lines the pulse up with the output flop stage behind cnt.
    assign cnt_o          = cnt_q;
    assign tick_o         = tick;
    assign wrap_o         = wrap;
    assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM: register file, double-buffered duties, comparators and output flops.
// Duties written by the host are pending until the timebase reports a period boundary.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int NUM_CH  = 16,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [6:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [6:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic              period_start,
    output logic [NUM_CH-1:0] out
);

    localparam int NUM_BYTES = NUM_CH / 8;

    logic [NUM_CH-1:0]  out_en_q, out_en_d;
    logic [NUM_CH-1:0]  pwm_en_q, pwm_en_d;
    logic               center_q, center_d;
    logic               run_q, run_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         duty_pend_q [NUM_CH];
    logic [7:0]         duty_pend_d [NUM_CH];
    logic [7:0]         duty_act_q  [NUM_CH];
    logic [7:0]         duty_act_d  [NUM_CH];
    logic [NUM_CH-1:0]  out_q, out_d;
    logic [7:0]         rd_data_q, rd_data_d;

    logic [7:0] cnt;
    logic       tick, wrap, load;

    pwm_timebase #(
        .PRESC_W(PRESC_W)
    ) u_timebase (
        .clk           (clk),
        .rst           (rst),
        .run_i         (run_q),
        .center_i      (center_q),
        .presc_i       (presc_q),
        .cnt_o         (cnt),
        .tick_o        (tick),
        .wrap_o        (wrap),
        .period_start_o(period_start)
    );

    assign load = tick && wrap;

    // Byte lanes beyond NUM_BYTES and duty slots beyond NUM_CH simply never match.
    always_comb begin
        out_en_d    = out_en_q;
        pwm_en_d    = pwm_en_q;
        center_d    = center_q;
        run_d       = run_q;
        presc_d     = presc_q;
        duty_pend_d = duty_pend_q;
        if (wr_en) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (wr_addr == ADDR_OUT_EN + 7'(k)) begin
                    out_en_d[8*k +: 8] = wr_data;
                end
                if (wr_addr == ADDR_PWM_EN + 7'(k)) begin
                    pwm_en_d[8*k +: 8] = wr_data;
                end
            end
            if (wr_addr == ADDR_CTRL) begin
                center_d = wr_data[CTRL_CENTER];
                run_d    = wr_data[CTRL_RUN];
            end
            if (wr_addr == ADDR_PRESC) begin
                presc_d = wr_data[PRESC_W-1:0];
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (wr_addr == ADDR_DUTY_BASE + 7'(ch)) begin
                    duty_pend_d[ch] = wr_data;
                end
            end
        end
    end

    // Stopped: active follows pending so the first period after run uses fresh duties.
    always_comb begin
        duty_act_d = duty_act_q;
        if (!run_q || load) begin
            duty_act_d = duty_pend_q;
        end
    end

    always_comb begin
        rd_data_d = 8'd0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (rd_addr == ADDR_OUT_EN + 7'(k)) begin
                rd_data_d = out_en_q[8*k +: 8];
            end
            if (rd_addr == ADDR_PWM_EN + 7'(k)) begin
                rd_data_d = pwm_en_q[8*k +: 8];
            end
        end
        if (rd_addr == ADDR_CTRL) begin
            rd_data_d[CTRL_CENTER] = center_q;
            rd_data_d[CTRL_RUN]    = run_q;
        end
        if (rd_addr == ADDR_PRESC) begin
            rd_data_d = 8'(presc_q);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (rd_addr == ADDR_DUTY_BASE + 7'(ch)) begin
                rd_data_d = duty_pend_q[ch];
            end
        end
    end

    // A channel with PWM disabled but output enabled is a static high.
    always_comb begin
        out_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            out_d[ch] = out_en_q[ch] & (~pwm_en_q[ch] | pwm_level(cnt, duty_act_q[ch]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_en_q    <= '0;
            pwm_en_q    <= '0;
            center_q    <= 1'b0;
            run_q       <= 1'b0;
            presc_q     <= '0;
            duty_pend_q <= '{default: 8'd0};
            duty_act_q  <= '{default: 8'd0};
            out_q       <= '0;
            rd_data_q   <= 8'd0;
        end else begin
            out_en_q    <= out_en_d;
            pwm_en_q    <= pwm_en_d;
            center_q    <= center_d;
            run_q       <= run_d;
            presc_q     <= presc_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            out_q       <= out_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign out     = out_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel: expectations go into a queue, observations are
// compared by a separate monitor process as they are presented.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int NUM_CH  = 16;
  localparam int PRESC_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [6:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        rd_addr;
  logic [7:0]        rd_data;
  logic              period_start;
  logic [NUM_CH-1:0] out;

  pwm_multi_channel #(
    .NUM_CH (NUM_CH),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .period_start(period_start),
    .out         (out)
  );

  // Clock / reset: inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  string       name_q[$];
  event        obs_ev;
  int          n_checks = 0;
  int          n_errors = 0;

  int                hi_cnt[NUM_CH];
  int                per_len;
  logic [NUM_CH-1:0] first_out;
  logic [NUM_CH-1:0] last_out;

  // Scoreboard monitor
  initial begin
    logic [31:0] a;
    logic [31:0] e;
    string       n;
    forever begin
      @(obs_ev);
      while (obs_q.size() > 0) begin
        a = obs_q.pop_front();
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_observation actual=%0d required=none", a);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (a !== e) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
          end
        end
      end
    end
  end

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
    -> obs_ev;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    expect_val(n, req);
    observe(act);
  endtask

  // Driver tasks
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input string n, input logic [6:0] a, input logic [7:0] req);
    rd_addr = a;
    expect_val(n, 32'(req));
    @(negedge clk);
    observe(32'(rd_data));
  endtask

  task automatic wait_ps(input int lim);
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (period_start !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_period_start actual=no_pulse required=pulse_within_%0d", lim);
    end
  endtask

  // Called on a period_start cycle; counts cycles and high cycles up to the next pulse.
  task automatic measure(input int lim, input int wr_at, input logic [6:0] wa, input logic [7:0] wd);
    per_len = 0;
    foreach (hi_cnt[i]) hi_cnt[i] = 0;
    first_out = out;
    do begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (out[i]) hi_cnt[i]++;
      end
      last_out = out;
      if (per_len == wr_at) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      per_len++;
      @(negedge clk);
    end while (period_start !== 1'b1 && per_len < lim);
    wr_en = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 7'd0;
    wr_data = 8'd0;
    rd_addr = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_period_start", 32'(period_start), 32'd0);
    rst = 1'b0;

    // Static-high output: out_en only, pwm disabled
    wr(ADDR_OUT_EN, 8'h01);
    chk("oe_register_stage", 32'(out), 32'd0);
    @(negedge clk);
    chk("oe_output_stage", 32'(out), 32'h0001);
    rd("rd_out_en0", ADDR_OUT_EN, 8'h01);

    // Ignored writes and unmapped reads
    wr(7'h0A, 8'hFF);
    rd("rd_unmapped_0a", 7'h0A, 8'h00);
    wr(7'h02, 8'hFF);
    rd("rd_out_en_byte2", 7'h02, 8'h00);
    wr(7'h20, 8'h55);
    rd("rd_duty_ch16", 7'h20, 8'h00);
    chk("out_after_ignored", 32'(out), 32'h0001);
    rd("rd_presc_reset", ADDR_PRESC, 8'h00);

    // Edge mode, presc 0: ch0=0x80, ch3=0x00, ch4=0xFF
    wr(ADDR_DUTY_BASE + 7'd0, 8'h80);
    wr(ADDR_DUTY_BASE + 7'd3, 8'h00);
    wr(ADDR_DUTY_BASE + 7'd4, 8'hFF);
    wr(ADDR_OUT_EN, 8'h1F);
    wr(ADDR_PWM_EN, 8'h1F);
    wr(ADDR_PRESC, 8'd0);
    wr(ADDR_CTRL, 8'h02);
    rd("rd_duty0", ADDR_DUTY_BASE, 8'h80);
    wait_ps(2000);
    measure(3000, -1, 7'd0, 8'd0);
    chk("edge_period", 32'(per_len), 32'd255);
    chk("edge_ch0_high", 32'(hi_cnt[0]), 32'd128);
    chk("edge_ch1_high", 32'(hi_cnt[1]), 32'd0);
    chk("edge_ch3_high", 32'(hi_cnt[3]), 32'd0);
    chk("edge_ch4_high", 32'(hi_cnt[4]), 32'd255);
    measure(3000, -1, 7'd0, 8'd0);
    chk("edge_period_2", 32'(per_len), 32'd255);

    // Center mode, presc 3: 510 ticks of 4 clks; duty d is high for 2d-1 ticks
    wr(ADDR_DUTY_BASE + 7'd1, 8'h40);
    wr(ADDR_CTRL, 8'h03);
    wr(ADDR_PRESC, 8'd3);
    rd("rd_ctrl", ADDR_CTRL, 8'h03);
    rd("rd_presc", ADDR_PRESC, 8'h03);
    wait_ps(4000);
    measure(6000, -1, 7'd0, 8'd0);
    chk("center_period", 32'(per_len), 32'd2040);
    chk("center_ch0_high", 32'(hi_cnt[0]), 32'd1020);
    chk("center_ch1_high", 32'(hi_cnt[1]), 32'd508);
    chk("center_ch3_high", 32'(hi_cnt[3]), 32'd0);
    chk("center_ch4_high", 32'(hi_cnt[4]), 32'd2040);
    chk("center_ch1_first", 32'(first_out[1]), 32'd1);
    chk("center_ch1_last", 32'(last_out[1]), 32'd1);

    // Back to edge mode; ch2 duty changed mid-period is deferred to the next boundary
    wr(ADDR_DUTY_BASE + 7'd2, 8'h20);
    wr(ADDR_CTRL, 8'h02);
    wr(ADDR_PRESC, 8'd0);
    rd_addr = ADDR_DUTY_BASE + 7'd2;
    wait_ps(4000);
    measure(3000, 100, ADDR_DUTY_BASE + 7'd2, 8'hC0);
    chk("dchg_period_old", 32'(per_len), 32'd255);
    chk("dchg_ch2_old_high", 32'(hi_cnt[2]), 32'd32);
    chk("dchg_rd_pending", 32'(rd_data), 32'hC0);
    measure(3000, -1, 7'd0, 8'd0);
    chk("dchg_period_new", 32'(per_len), 32'd255);
    chk("dchg_ch2_new_high", 32'(hi_cnt[2]), 32'd192);
    chk("dchg_ch0_high", 32'(hi_cnt[0]), 32'd128);

    // Reset mid-period with everything running
    repeat (60) @(negedge clk);
    rd_addr = ADDR_DUTY_BASE;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_period_start", 32'(period_start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rd_duty0", 32'(rd_data), 32'd0);
    chk("midrst_out_after", 32'(out), 32'd0);

    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unconsumed_expectations actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
